// File: rtl/lsu.sv
// lsu: MIPS32 memory-stage load/store unit in front of a 1024-word data RAM.
// Loads: 2-cycle response; SW: 1 cycle; SB/SH read-modify-write: 3 cycles; misaligned error: 1 cycle.
// One request outstanding; req_ready is low from acceptance until the response cycle.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (defined: misaligned accesses respond with resp_err;
// undefined: the address is aligned down and the access proceeds).
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_addr,
  output logic [31:0] m_din,
  input  logic [31:0] m_dout
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_ERR} state_t;

  state_t      state_q;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;

  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;
  logic        m_read_q;
  logic        m_write_q;
  logic [31:0] m_addr_q;
  logic [31:0] m_din_q;

  logic        accept;
  logic        req_is_half;
  logic        req_is_word;
  logic [1:0]  req_lane;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign accept      = req_valid & req_ready_q;
  assign req_is_half = (req_size == 2'b01);
  // size 11 behaves as a word
  assign req_is_word = req_size[1];

`ifdef LSU_MISALIGN_TRAP_EN
  logic req_misal;
  assign req_misal = (req_is_half & req_addr[0]) | (req_is_word & (req_addr[1:0] != 2'b00));
`endif

  // Lane of the request; without trapping, misaligned addresses are aligned down here
  always_comb begin
    req_lane = req_addr[1:0];
`ifndef LSU_MISALIGN_TRAP_EN
    if (req_is_half) begin
      req_lane = {req_addr[1], 1'b0};
    end else if (req_is_word) begin
      req_lane = 2'b00;
    end
`endif
  end

  // Big-endian lane extraction and sign/zero extension of the RAM word
  always_comb begin
    case (lane_q)
      2'd0:    byte_sel = m_dout[31:24];
      2'd1:    byte_sel = m_dout[23:16];
      2'd2:    byte_sel = m_dout[15:8];
      default: byte_sel = m_dout[7:0];
    endcase
    half_sel = lane_q[1] ? m_dout[15:0] : m_dout[31:16];
    case (size_q)
      2'b00:   load_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
      default: load_ext = m_dout;
    endcase
  end

  // Merge sub-word store data into the word read back from RAM
  always_comb begin
    merged = m_dout;
    if (size_q == 2'b00) begin
      case (lane_q)
        2'd0:    merged[31:24] = wdata_q[7:0];
        2'd1:    merged[23:16] = wdata_q[7:0];
        2'd2:    merged[15:8]  = wdata_q[7:0];
        default: merged[7:0]   = wdata_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      merged[15:0] = wdata_q;
    end else begin
      merged[31:16] = wdata_q;
    end
  end

  // Control FSM with registered RAM and response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= 2'b00;
      lane_q       <= 2'b00;
      wdata_q      <= 16'h0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      m_read_q     <= 1'b0;
      m_write_q    <= 1'b0;
      m_addr_q     <= 32'h0;
      m_din_q      <= 32'h0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      m_read_q     <= 1'b0;
      m_write_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            we_q        <= req_we;
            uns_q       <= req_unsigned;
            size_q      <= req_size;
            lane_q      <= req_lane;
            wdata_q     <= req_wdata[15:0];
            m_addr_q    <= {2'b00, req_addr[31:2]};
            req_ready_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            if (req_misal) begin
              state_q <= S_ERR;
            end else
`endif
            if (req_we && req_is_word) begin
              state_q   <= S_WR;
              m_write_q <= 1'b1;
              m_din_q   <= req_wdata;
            end else begin
              state_q  <= S_RD;
              m_read_q <= 1'b1;
            end
          end
        end
        S_RD: begin
          state_q <= S_CAP;
        end
        S_CAP: begin
          if (!we_q) begin
            resp_rdata_q <= load_ext;
            resp_valid_q <= 1'b1;
            req_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
          end else begin
            m_din_q   <= merged;
            m_write_q <= 1'b1;
            state_q   <= S_WR;
          end
        end
        S_WR: begin
          resp_valid_q <= 1'b1;
          req_ready_q  <= 1'b1;
          state_q      <= S_IDLE;
        end
        S_ERR: begin
          resp_valid_q <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
          resp_err_q   <= 1'b1;
`endif
          req_ready_q  <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: begin
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign m_read     = m_read_q;
  assign m_write    = m_write_q;
  assign m_addr     = m_addr_q;
  assign m_din      = m_din_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed load/store vectors against lsu with a behavioural word RAM.
// Expected responses are queued at acceptance and checked by an independent monitor.
// Honours LSU_MISALIGN_TRAP_EN to pick the misaligned-access expectations.
`timescale 1ns/1ps
module tb_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_addr;
  logic [31:0] m_din;
  logic [31:0] m_dout;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_din(m_din),
    .m_dout(m_dout)
  );

  // Word RAM with registered read
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (m_write) mem[m_addr[9:0]] <= m_din;
    if (m_read)  m_dout <= mem[m_addr[9:0]];
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    logic [31:0] maddr;
    logic [31:0] din;
    int          nrd;
    int          nwr;
    int          id;
  } exp_t;

  exp_t sb_q[$];
  int   resp_cycs[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   next_id = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: RAM accesses and responses against the queued expectations
  int rd_cnt = 0;
  int wr_cnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_cnt = 0;
        wr_cnt = 0;
      end else begin
        if (m_read || m_write) begin
          if (sb_q.size() == 0) chk("ram access without request", sb_q.size(), 1);
          else begin
            chk($sformatf("m_addr#%0d", sb_q[0].id), m_addr, sb_q[0].maddr);
            if (m_read) rd_cnt++;
            if (m_write) begin
              wr_cnt++;
              chk($sformatf("m_din#%0d", sb_q[0].id), m_din, sb_q[0].din);
            end
          end
        end
        if (resp_valid) begin
          if (sb_q.size() == 0) chk("response without request", sb_q.size(), 1);
          else begin
            exp_t e;
            e = sb_q.pop_front();
            chk($sformatf("rdata#%0d", e.id), resp_rdata, e.rdata);
            chk($sformatf("err#%0d", e.id), {31'b0, resp_err}, {31'b0, e.err});
            chk($sformatf("latency#%0d", e.id), cyc - e.acc, e.lat);
            chk($sformatf("m_read cycles#%0d", e.id), rd_cnt, e.nrd);
            chk($sformatf("m_write cycles#%0d", e.id), wr_cnt, e.nwr);
            resp_cycs.push_back(cyc);
          end
          rd_cnt = 0;
          wr_cnt = 0;
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] erd, input logic eerr, input int lat,
                       input int nrd, input int nwr, input logic [31:0] din);
    exp_t e;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk); #1;
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      if (req_ready) break;
    end
    if (!req_ready) chk("req_ready (accept timeout)", {31'b0, req_ready}, 1);
    else begin
      e.rdata = erd; e.err = eerr; e.lat = lat; e.acc = cyc + 1;
      e.maddr = {2'b00, addr[31:2]}; e.din = din; e.nrd = nrd; e.nwr = nwr;
      e.id = next_id;
      next_id++;
      sb_q.push_back(e);
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done();
    for (int t = 0; t < 30; t++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk); #1;
    end
    if (sb_q.size() != 0) begin
      chk("response timeout", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  task automatic ld(input logic [1:0] size, input logic uns, input logic [31:0] addr, input logic [31:0] erd);
    issue(1'b0, size, uns, addr, 32'h0, erd, 1'b0, 2, 1, 0, 32'h0);
    req_valid = 1'b0;
    wait_done();
  endtask

  task automatic sw(input logic [31:0] addr, input logic [31:0] data);
    issue(1'b1, 2'b10, 1'b0, addr, data, 32'h0, 1'b0, 1, 0, 1, data);
    req_valid = 1'b0;
    wait_done();
  endtask

  task automatic st_sub(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] din);
    issue(1'b1, size, 1'b0, addr, wdata, 32'h0, 1'b0, 3, 1, 1, din);
    req_valid = 1'b0;
    wait_done();
  endtask

  task automatic misal(input logic we, input logic [1:0] size, input logic [31:0] addr);
    issue(we, size, 1'b0, addr, 32'h12345678, 32'h0, 1'b1, 1, 0, 0, 32'h0);
    req_valid = 1'b0;
    wait_done();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " req_ready"}, {31'b0, req_ready}, 1);
    chk({tag, " resp_valid"}, {31'b0, resp_valid}, 0);
    chk({tag, " resp_rdata"}, resp_rdata, 32'h0);
    chk({tag, " resp_err"}, {31'b0, resp_err}, 0);
    chk({tag, " m_read"}, {31'b0, m_read}, 0);
    chk({tag, " m_write"}, {31'b0, m_write}, 0);
    chk({tag, " m_addr"}, m_addr, 32'h0);
    chk({tag, " m_din"}, m_din, 32'h0);
  endtask

  initial begin
    @(negedge clk); #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // SW then LW of the same word
    sw(32'h10, 32'hDEADBEEF);
    ld(2'b10, 1'b0, 32'h10, 32'hDEADBEEF);

    // Sub-word loads, big-endian lanes
    sw(32'h20, 32'h11223344);
    ld(2'b00, 1'b0, 32'h23, 32'h00000044);
    ld(2'b00, 1'b1, 32'h20, 32'h00000011);
    ld(2'b01, 1'b0, 32'h22, 32'h00003344);
    sw(32'h20, 32'h80FF0000);
    ld(2'b00, 1'b0, 32'h20, 32'hFFFFFF80);
    ld(2'b01, 1'b1, 32'h20, 32'h000080FF);
    ld(2'b01, 1'b0, 32'h20, 32'hFFFF80FF);
    ld(2'b00, 1'b0, 32'h21, 32'hFFFFFFFF);
    ld(2'b00, 1'b1, 32'h21, 32'h000000FF);
    ld(2'b11, 1'b1, 32'h20, 32'h80FF0000);

    // Read-modify-write sub-word stores
    sw(32'h30, 32'h11223344);
    st_sub(2'b00, 32'h31, 32'h123456AA, 32'h11AA3344);
    st_sub(2'b01, 32'h32, 32'h9999BEEF, 32'h11AABEEF);
    ld(2'b10, 1'b0, 32'h30, 32'h11AABEEF);

    // Misaligned accesses
    sw(32'h40, 32'hCAFEF00D);
`ifdef LSU_MISALIGN_TRAP_EN
    misal(1'b0, 2'b10, 32'h41);
    misal(1'b1, 2'b01, 32'h43);
    ld(2'b10, 1'b0, 32'h40, 32'hCAFEF00D);
`else
    ld(2'b10, 1'b0, 32'h41, 32'hCAFEF00D);
    st_sub(2'b01, 32'h43, 32'h00001234, 32'hCAFE1234);
    ld(2'b10, 1'b0, 32'h40, 32'hCAFE1234);
`endif

    // Reset during the CAP cycle of an SB aborts it without a write
    issue(1'b1, 2'b00, 1'b0, 32'h30, 32'h00000055, 32'h0, 1'b0, 3, 1, 1, 32'h55AABEEF);
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("abort");
    sb_q.delete();
    req_valid = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    ld(2'b10, 1'b0, 32'h30, 32'h11AABEEF);

    // Back-to-back loads with req_valid held high
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h11AABEEF, 1'b0, 2, 1, 0, 32'h0);
    req_valid = 1'b0;
    wait_done();
    if (resp_cycs.size() >= 2)
      chk("b2b response spacing", resp_cycs[resp_cycs.size()-1] - resp_cycs[resp_cycs.size()-2], 3);
    else
      chk("b2b response count", resp_cycs.size(), 2);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
